// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch queue.
package fetch_pkg;

  localparam int unsigned IW         = 16;
  localparam int unsigned AW         = 16;
  localparam int unsigned OPCODE_W   = 6;
  localparam int unsigned OPERAND_W  = 10;
  localparam int unsigned OPCODE_MSB = 15;
  localparam int unsigned OPCODE_LSB = 10;

  localparam logic [AW-1:0] RESET_PC = 16'h0000;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO of fetch entries: push/pop with a single-cycle flush to empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  fetch_entry_t push_entry,
  input  logic         pop,
  input  logic         flush,
  output fetch_entry_t head_entry,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic          do_pop;

  // A pop on an empty queue is ignored.
  assign do_pop     = pop && (count != '0);
  assign head_entry = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PW'(1);
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      count <= count + CW'(push) - CW'(do_pop);
    end
  end

  // Storage is cleared on reset so the head reads as zero afterwards.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (push && !flush) begin
      mem[wr_ptr] <= push_entry;
    end
  end

  a_count_bound: assert property (@(posedge clk) disable iff (rst)
    count <= CW'(DEPTH));

  a_no_write_full: assert property (@(posedge clk) disable iff (rst)
    !(push && !flush && (count == CW'(DEPTH))));

endmodule

// File: rtl/instr_fetch_queue.sv
// Fetch stage: credit-based sequential reads into a prefetch FIFO, head split
// into opcode/operand for decode; redirect flushes and restarts fetch.
module instr_fetch_queue #(
  parameter  int unsigned     DEPTH    = 4,
  parameter  int unsigned     AW       = 16,
  parameter  int unsigned     IW       = 16,
  parameter  logic [AW-1:0]   RESET_PC = 16'h0000,
  localparam int unsigned     CW       = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic [IW-1:0] imem_rdata,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [IW-1:0] out_instr,
  output logic [AW-1:0] out_pc,
  output logic [5:0]    out_opcode,
  output logic [9:0]    out_operand,
  output logic [AW-1:0] fetch_pc,
  output logic [CW-1:0] count
);

  import fetch_pkg::*;

  logic          inflight;
  logic [AW-1:0] pend_pc;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Occupancy plus the outstanding read must leave room, so a response
  // always finds a free slot.
  assign imem_req  = !rst && !redirect &&
                     (({1'b0, count} + (CW+1)'(inflight)) < (CW+1)'(DEPTH));
  assign imem_addr = fetch_pc;

  // A response landing in a redirect cycle belongs to the old stream.
  assign push             = inflight && !redirect;
  assign pop              = out_valid && out_ready;
  assign push_entry.pc    = pend_pc;
  assign push_entry.instr = imem_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      inflight <= 1'b0;
      pend_pc  <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        fetch_pc <= fetch_pc + AW'(1);
        pend_pc  <= fetch_pc;
      end
    end
  end

  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (redirect),
    .head_entry (head_entry),
    .count      (count)
  );

  assign out_valid   = (count != '0);
  assign out_instr   = head_entry.instr;
  assign out_pc      = head_entry.pc;
  assign out_opcode  = out_instr[OPCODE_MSB:OPCODE_LSB];
  assign out_operand = out_instr[OPCODE_LSB-1:0];

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the IR/AR opcode/operand split.
- Issues sequential word reads to the instruction memory and buffers returned words with their addresses in a small prefetch FIFO.
- Presents the head instruction to decode through a valid/ready handshake, already split into opcode[15:10] and operand[9:0].
- A redirect (taken branch, call, return) flushes the queue and any read in flight, then restarts fetch at the new PC.

Parameters:
- DEPTH, 4, queue entries; power of two, at least 2.
- AW, 16, instruction address width.
- IW, 16, instruction width.
- RESET_PC, 16'h0000, fetch address after reset.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_req  out  1  read request this cycle.
- imem_addr  out  AW  read address; valid when imem_req=1.
- imem_rdata  in  IW  read data; valid exactly one cycle after the request.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  AW  new fetch address; sampled when redirect=1.
- out_valid  out  1  head entry available.
- out_ready  in  1  decode accepts head.
- out_instr  out  IW  head instruction.
- out_pc  out  AW  address of head instruction.
- out_opcode  out  6  out_instr[15:10].
- out_operand  out  10  out_instr[9:0].
- fetch_pc  out  AW  next address to request.
- count  out  $clog2(DEPTH)+1  occupied entries.

Behaviour:
- Reset (async, any time) sets:
  - fetch_pc=RESET_PC; count=0; out_valid=0.
  - imem_req=0; in-flight flag=0.
  - rd/wr pointers=0.
  - out_instr/out_pc=0, because storage is cleared on reset.
- Reset mid-operation drops any pending read response.
- Issue rule: imem_req=1 iff !rst, !redirect, and (count + inflight) < DEPTH.
  - Credit counting this way means a response never finds the queue full.
  - imem_addr=fetch_pc.
  - fetch_pc increments by 1 on each issue, wrapping 16'hFFFF→16'h0000.
- Response: the cycle after an issue, imem_rdata is written at wr_ptr together with its pc.
  - The pc is held from issue time in a registered pending-address.
  - wr_ptr advances mod DEPTH.
- Dequeue: when out_valid && out_ready, rd_ptr advances mod DEPTH.
- out_* are driven from the head entry.
  - out_valid = (count != 0).
  - No bypass from imem_rdata to out_*.
  - Minimum latency from req to out_valid is 2 cycles.
- Simultaneous write and dequeue: count unchanged, both pointers advance.
- Steady state with out_ready held at 1 gives one instruction per cycle.
- Full: count==DEPTH with nothing in flight stalls issue. Issue resumes in the cycle after a dequeue frees a credit.
- Empty: out_valid=0; out_ready is ignored.
- Redirect (has priority over everything except reset), in the redirect cycle:
  - imem_req=0.
  - A handshake in that cycle still completes; that entry is the redirecting instruction itself.
- At the clock edge after redirect:
  - count=0; pointers=0.
  - The in-flight response, if any, is discarded and never written.
  - fetch_pc=redirect_pc.
  - Issue resumes in the following cycle from redirect_pc.
- Back-to-back redirects: the last one wins; no request is issued between them.
- count never exceeds DEPTH, and a write never coincides with a full queue. Both are checked with assertions.

Decomposition:
- Shared package fetch_pkg holds:
  - Constants IW=16, AW=16, OPCODE_W=6, OPERAND_W=10, RESET_PC.
  - Slice positions OPCODE_MSB=15, OPCODE_LSB=10.
  - fetch_entry_t = {pc[AW-1:0], instr[IW-1:0]}.
- One sub-module, fetch_fifo:
  - Parameterised DEPTH synchronous FIFO of fetch_entry_t.
  - Has push, pop, flush, count, and an async-reset pointer pair.
- Top level holds fetch_pc, the in-flight/pending-address register, issue logic and the opcode/operand split.

Test Plan:
- Reset release, memory word k at address k, out_ready=1:
  - imem_req first high the cycle after reset drops.
  - out_valid high 2 cycles after the first req.
  - out_pc sequence 0,1,2,… one per cycle; out_opcode/out_operand match [15:10]/[9:0].
- out_ready=0 for 10 cycles:
  - Exactly 4 requests issued; count=4; imem_req stays 0.
  - On out_ready=1, the next request issues the cycle after the first dequeue.
  - No duplicates or drops.
- Redirect to 16'h0040 while count=3 and a read is in flight:
  - Next cycle count=0 and out_valid=0; the stale response is not enqueued.
  - The next out_pc is 16'h0040.
- Redirect in two consecutive cycles to 16'h0010 then 16'h0020:
  - No request between them.
  - First delivered out_pc is 16'h0020.
- RESET_PC=16'hFFFE, out_ready=1:
  - out_pc sequence FFFE, FFFF, 0000, 0001.
- Assert rst while count=2 with a read in flight:
  - out_valid=0 and count=0 immediately, without waiting for a clock edge.
  - After release, fetch restarts at RESET_PC.
